// File: rtl/instrument_packet_tx.sv
// rtl/instrument_packet_tx.sv - instrument state packer and 8N1 UART transmitter, change-driven round-robin
// Optional periodic resend of all instrument states: define INST_TX_REFRESH_EN.
module instrument_packet_tx #(
  parameter int BAUD_DIV       = 434,
  parameter int REFRESH_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] bass,
  input  logic [4:0] drum,
  input  logic [4:0] guitar,
  output logic       TxD,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] sent_id
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  state_t      state, state_next;
  logic [15:0] baud_cnt;
  logic        baud_done;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;

  logic [4:0]  smp_bass, smp_drum, smp_guitar;
  logic [4:0]  last_bass, last_drum, last_guitar;
  logic [2:0]  pending, pending_next, diff;
  logic [3:0]  pend4;
  logic [1:0]  rr, pick;
  logic [2:0]  cand;
  logic        load;
  logic [4:0]  load_data;
  logic [2:0]  load_id;
  logic        refresh_wrap;

`ifdef INST_TX_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  logic [RW-1:0] refresh_cnt;

  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || refresh_wrap) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end
`else
  assign refresh_wrap = 1'b0;
`endif

  assign baud_done = (baud_cnt == 16'd0);
  assign diff      = {smp_guitar != last_guitar, smp_drum != last_drum, smp_bass != last_bass};
  assign pend4     = {1'b0, pending};

  // Round-robin pick: scan rr, rr+1, rr+2 (mod 3); the nearest pending one wins.
  always_comb begin
    pick = rr;
    cand = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, rr} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (pend4[cand[1:0]]) begin
        pick = cand[1:0];
      end
    end
  end

  always_comb begin
    load_data = smp_guitar;
    load_id   = 3'b100;
    case (pick)
      2'd0: begin
        load_data = smp_bass;
        load_id   = 3'b001;
      end
      2'd1: begin
        load_data = smp_drum;
        load_id   = 3'b010;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    frame_done = 1'b0;
    TxD        = 1'b1;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|pending) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        TxD = 1'b0;
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        TxD = shift[0];
        if (baud_done && bit_cnt == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (baud_done) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A refresh wins over the clear of the instrument being loaded in the same cycle.
  always_comb begin
    pending_next = pending | diff;
    if (load) pending_next[pick] = 1'b0;
    if (refresh_wrap) pending_next = 3'b111;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= BAUD_RELOAD;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      smp_bass    <= 5'd0;
      smp_drum    <= 5'd0;
      smp_guitar  <= 5'd0;
      last_bass   <= 5'd0;
      last_drum   <= 5'd0;
      last_guitar <= 5'd0;
      pending     <= 3'b111;
      rr          <= 2'd0;
      sent_id     <= 3'd0;
    end else begin
      state      <= state_next;
      smp_bass   <= bass;
      smp_drum   <= drum;
      smp_guitar <= guitar;
      pending    <= pending_next;

      if (state == IDLE || baud_done) begin
        baud_cnt <= BAUD_RELOAD;
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end

      if (load) begin
        shift   <= {load_data, load_id};
        sent_id <= load_id;
        rr      <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
        case (pick)
          2'd0:    last_bass   <= load_data;
          2'd1:    last_drum   <= load_data;
          default: last_guitar <= load_data;
        endcase
      end else if (state == DATA && baud_done) begin
        shift <= {1'b0, shift[7:1]};
      end

      if (state == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (state == DATA && baud_done) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_instrument_packet_tx.sv
// tb/tb_instrument_packet_tx.sv - self-checking bench for instrument_packet_tx
module tb_instrument_packet_tx;

  localparam int BD    = 4;
  localparam int RC    = 200;
  localparam int FRAME = 10 * BD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] bass = 5'd0, drum = 5'd0, guitar = 5'd0;
  logic       TxD, busy, frame_done;
  logic [2:0] sent_id;

  instrument_packet_tx #(.BAUD_DIV(BD), .REFRESH_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .bass(bass), .drum(drum), .guitar(guitar),
    .TxD(TxD), .busy(busy), .frame_done(frame_done), .sent_id(sent_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: a frame occupies FRAME cycles after its load edge.
  logic [4:0] m_s[3];
  logic [4:0] m_l[3];
  logic [2:0] m_p;
  int         m_rr, m_rem;
  logic [7:0] m_byte;
  logic [2:0] m_sid;
`ifdef INST_TX_REFRESH_EN
  int         m_rc;
`endif

  task automatic model_edge();
    logic [4:0] inp[3];
    logic [2:0] np;
    int         j;
    bit         wrap;
    inp[0] = bass; inp[1] = drum; inp[2] = guitar;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_s[i] = 5'd0;
        m_l[i] = 5'd0;
      end
      m_p = 3'b111; m_rr = 0; m_rem = 0; m_byte = 8'd0; m_sid = 3'd0;
`ifdef INST_TX_REFRESH_EN
      m_rc = 0;
`endif
    end else begin
      wrap = 1'b0;
`ifdef INST_TX_REFRESH_EN
      wrap = (m_rc == RC - 1);
      m_rc = wrap ? 0 : m_rc + 1;
`endif
      for (int i = 0; i < 3; i++) np[i] = m_p[i] | (m_s[i] != m_l[i]);
      if (m_rem == 0 && m_p != 3'd0) begin
        j = -1;
        for (int k = 0; k < 3; k++)
          if (j < 0 && m_p[(m_rr + k) % 3]) j = (m_rr + k) % 3;
        m_sid  = 3'(1 << j);
        m_byte = {m_s[j], m_sid};
        m_l[j] = m_s[j];
        np[j]  = 1'b0;
        m_rr   = (j + 1) % 3;
        m_rem  = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (wrap) np = 3'b111;
      m_p = np;
      for (int i = 0; i < 3; i++) m_s[i] = inp[i];
    end
  endtask

  function automatic int exp_txd();
    int b;
    if (m_rem == 0) return 1;
    b = (FRAME - m_rem) / BD;
    if (b == 0) return 0;
    if (b <= 8) return int'(m_byte[b-1]);
    return 1;
  endfunction

  // Independent UART decoder sampling mid-bit.
  logic [7:0] rx_q[$];
  bit         dec_on = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'd0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("txd", int'(TxD), exp_txd());
    chk("busy", int'(busy), int'(m_rem != 0));
    chk("frame_done", int'(frame_done), int'(m_rem == 1));
    chk("sent_id", int'(sent_id), int'(m_sid));
    if (!rst_n) begin
      dec_on = 1'b0;
    end else if (dec_on) begin
      dec_cnt++;
      if (dec_cnt % BD == BD / 2 && dec_cnt / BD >= 1 && dec_cnt / BD <= 8) begin
        dec_byte[dec_cnt / BD - 1] = TxD;
      end else if (dec_cnt == 9 * BD + BD / 2) begin
        chk("stop_bit", int'(TxD), 1);
        rx_q.push_back(dec_byte);
        dec_on = 1'b0;
      end
    end else if (TxD == 1'b0) begin
      dec_on  = 1'b1;
      dec_cnt = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_busy(input string name);
    int t = 0;
    while (!busy && t < 300) begin
      step();
      t++;
    end
    chk({name, "_wait_busy"}, int'(busy), 1);
  endtask

  task automatic chk_rx(input string name, input int n, input logic [2:0][7:0] e);
    chk({name, "_count"}, rx_q.size(), n);
    for (int k = 0; k < n; k++)
      if (k < rx_q.size()) chk({name, "_byte"}, int'(rx_q[k]), int'(e[k]));
  endtask

  typedef struct {
    logic [4:0]       b, d, g;
    int               cycles;
    int               n;
    logic [2:0][7:0]  e;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t;
    int cnt;
    tbl[0] = '{5'h00, 5'h00, 5'h00, 140, 3, {8'h04, 8'h02, 8'h01}};
    tbl[1] = '{5'h00, 5'h00, 5'h16,  60, 1, {8'h00, 8'h00, 8'hB4}};
    tbl[2] = '{5'h1F, 5'h03, 5'h16, 100, 2, {8'h00, 8'h1A, 8'hF9}};
    tbl[3] = '{5'h03, 5'h03, 5'h16,  60, 1, {8'h00, 8'h00, 8'h19}};
    tbl[4] = '{5'h03, 5'h1F, 5'h1F, 100, 2, {8'h00, 8'hFC, 8'hFA}};

    rst_n = 1'b0;
    run(3);
    chk("reset_txd", int'(TxD), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_sent_id", int'(sent_id), 0);
    rst_n = 1'b1;
    rx_q.delete();

    for (int v = 0; v < 5; v++) begin
      bass = tbl[v].b; drum = tbl[v].d; guitar = tbl[v].g;
      run(tbl[v].cycles);
`ifndef INST_TX_REFRESH_EN
      chk_rx($sformatf("tbl%0d", v), tbl[v].n, tbl[v].e);
`endif
      rx_q.delete();
    end

    // Idle change to start-bit latency
    guitar = 5'h05;
    t = 0;
    while (TxD && t < 10) begin
      step();
      t++;
    end
    chk("latency", t, 3);
    run(45);
    rx_q.delete();

    // Repeated changes while queued collapse to the latest value
    bass = 5'h01;
    wait_busy("collapse");
    run(8);
    bass = 5'h02;
    run(8);
    bass = 5'h03;
    run(100);
`ifndef INST_TX_REFRESH_EN
    chk_rx("collapse", 2, {8'h00, 8'h19, 8'h09});
`endif

    // Reset during data bit 4 aborts the frame and re-arms the sync frames
    drum = 5'h07;
    wait_busy("rst_mid");
    run(4 + 16 + 1);
    bass = 5'h00; drum = 5'h00; guitar = 5'h00;
    rst_n = 1'b0;
    step();
    chk("rst_mid_txd", int'(TxD), 1);
    chk("rst_mid_busy", int'(busy), 0);
    rst_n = 1'b1;
    rx_q.delete();
    run(140);
`ifndef INST_TX_REFRESH_EN
    chk_rx("resync", 3, {8'h04, 8'h02, 8'h01});
`endif

    // Random input activity against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0:       bass   = 5'($urandom);
          1:       drum   = 5'($urandom);
          default: guitar = 5'($urandom);
        endcase
      end
      step();
    end

    // Static nonzero inputs: resends only with the refresh feature
    bass = 5'h0A; drum = 5'h15; guitar = 5'h1C;
    run(400);
    cnt = 0;
    for (int i = 0; i < 3 * RC; i++) begin
      step();
      if (frame_done) cnt++;
    end
`ifdef INST_TX_REFRESH_EN
    chk("refresh_frames", cnt, 9);
`else
    chk("no_resend", cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
